// File: rtl/pp_pkg.sv
// rtl/pp_pkg.sv - shared constants for the PP_1 input conditioning and state machine
package pp_pkg;

  localparam int PP_DB_CYCLES_DEFAULT = 4;

  // PP_1 state encodings, shared so both stages and their benches agree
  localparam logic [1:0] SA = 2'b00;
  localparam logic [1:0] SB = 2'b01;
  localparam logic [1:0] SC = 2'b10;
  localparam logic [1:0] SD = 2'b11;

endpackage

// File: rtl/pp_debounce.sv
// rtl/pp_debounce.sv - one input channel: synchroniser, debounce counter, rising-edge request
module pp_debounce
  import pp_pkg::*;
#(
  parameter int DB_CYCLES = PP_DB_CYCLES_DEFAULT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic raw,
  output logic req,
  output logic active
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic             r_db_q;
  logic [CNT_W-1:0] r_cnt;

  logic w_differs;
  logic w_accept;

  assign w_differs = (r_s2 != r_db);
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_db   <= 1'b0;
      r_db_q <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= raw;
      r_s2   <= r_s1;
      r_db_q <= r_db;
      // a level that reverts before acceptance restarts the count from zero
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign req    = r_db & ~r_db_q;
  assign active = (r_cnt != '0);

endmodule

// File: rtl/pp_input_cond.sv
// rtl/pp_input_cond.sv - debounced, arbitrated x/y pulse generator feeding PP_1
module pp_input_cond
  import pp_pkg::*;
#(
  parameter int DB_CYCLES = PP_DB_CYCLES_DEFAULT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic btn_x,
  input  logic btn_y,
  output logic x,
  output logic y,
  output logic busy
);

  logic w_req_x;
  logic w_req_y;
  logic w_act_x;
  logic w_act_y;
  logic w_ex;
  logic w_ey;
  logic w_x_nxt;
  logic w_y_nxt;
  logic w_pend_x_nxt;
  logic w_pend_y_nxt;

  logic r_pend_x;
  logic r_pend_y;

  pp_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db_x (
    .Clk    (Clk),
    .Rst    (Rst),
    .raw    (btn_x),
    .req    (w_req_x),
    .active (w_act_x)
  );

  pp_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db_y (
    .Clk    (Clk),
    .Rst    (Rst),
    .raw    (btn_y),
    .req    (w_req_y),
    .active (w_act_y)
  );

  assign w_ex = w_req_x | r_pend_x;
  assign w_ey = w_req_y | r_pend_y;

  // a pending channel beats a fresh request; otherwise X has priority
  always_comb begin
    w_x_nxt      = 1'b0;
    w_y_nxt      = 1'b0;
    w_pend_x_nxt = r_pend_x;
    w_pend_y_nxt = r_pend_y;
    if (w_ex && w_ey) begin
      if (r_pend_y && !r_pend_x) begin
        w_y_nxt      = 1'b1;
        w_pend_y_nxt = 1'b0;
        w_pend_x_nxt = 1'b1;
      end else begin
        w_x_nxt      = 1'b1;
        w_pend_x_nxt = 1'b0;
        w_pend_y_nxt = 1'b1;
      end
    end else if (w_ex) begin
      w_x_nxt      = 1'b1;
      w_pend_x_nxt = 1'b0;
    end else if (w_ey) begin
      w_y_nxt      = 1'b1;
      w_pend_y_nxt = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_pend_x <= 1'b0;
      r_pend_y <= 1'b0;
      x        <= 1'b0;
      y        <= 1'b0;
      busy     <= 1'b0;
    end else begin
      r_pend_x <= w_pend_x_nxt;
      r_pend_y <= w_pend_y_nxt;
      x        <= w_x_nxt;
      y        <= w_y_nxt;
      busy     <= w_act_x | w_act_y | r_pend_x | r_pend_y;
    end
  end

endmodule

// File: doc/pp_input_cond.md
# pp_input_cond

Input-conditioning stage that directly feeds the `PP_1` state machine's `x`/`y` inputs. It takes two raw, asynchronous push-button/switch lines, synchronises and debounces each one, and turns each debounced rising edge into a single-cycle pulse. It also arbitrates the two channels so `x` and `y` are never high in the same cycle. Its outputs connect straight to `PP_1` on the same `Clk`.

## Interface
- `DB_CYCLES`, default 4: consecutive synchronised cycles a new level must hold before it is accepted. Legal range is 1..255.
- `CNT_W`, derived as `$clog2(DB_CYCLES+1)`: width of the debounce counter. This is a localparam and cannot be overridden.

Ports:
- `Clk`  in  1: single clock; all flops are clocked on its rising edge.
- `Rst`  in  1: reset, asynchronous assert, active-low (0 = reset). Release is synchronous to `Clk` at the system level.
- `btn_x`  in  1: raw asynchronous input for channel X.
- `btn_y`  in  1: raw asynchronous input for channel Y.
- `x`  out  1: registered one-cycle pulse, one per accepted X press. Reset value 0.
- `y`  out  1: registered one-cycle pulse, one per accepted Y press. Reset value 0.
- `busy`  out  1: registered. High while any debounce counter is nonzero or any pend flag is set. Reset value 0.

## Operation
- **Synchroniser (per channel):** two-flop chain `s1`→`s2`, reset to 0.
- **Debounce (per channel):**
  - State is a stable level `db` (reset 0) and a counter `cnt` (reset 0).
  - `s2 == db`: `cnt` ← 0.
  - `s2 != db` and `cnt == DB_CYCLES-1`: `db` ← `s2`, `cnt` ← 0.
  - Otherwise: `cnt` ← `cnt+1`.
  - A level that reverts before acceptance clears `cnt`, so no pulse is produced.
- **Request:** `req` = `db & ~db_q`, where `db_q` is `db` delayed one cycle. Falling edges produce nothing.
- **Arbiter:** flags `pend_x` and `pend_y`, both reset 0.
  - Effective request per channel: `ex` = `req_x | pend_x`, `ey` = `req_y | pend_y`.
  - Exactly one of `ex`/`ey`: pulse that channel next cycle and clear its pend flag.
  - Both set: the channel whose pend flag is set wins. If neither or both pend flags are set, X wins. The loser's pend flag is set.
  - A channel already pending that sees a new `req` is not double-counted: one pend slot per channel, and the extra press is dropped.
- **Invariant:** `x & y` is never 1.

## Timing
- E0 is the first `Clk` edge that samples `btn_x` = 1, with `btn_x` held.
  - `s2` = 1 after E1.
  - `db` = 1 after E(1+DB_CYCLES).
  - `x` = 1 for exactly one cycle after E(2+DB_CYCLES).
  - With `DB_CYCLES`=4, `x` is high between E6 and E7.
- A simultaneous X/Y press gives `x` at E(2+DB_CYCLES) and `y` one cycle later.
- Release of a held button never pulses. A new press needs `db` to return to 0 first, which takes DB_CYCLES stable low cycles.
- **Reset mid-operation:** all flops clear immediately. Any in-flight or pending pulse is lost, and outputs go to 0 without waiting for a clock. A button still held at reset release is re-debounced from `db`=0 and yields one pulse per the latency above.
- `busy` goes high the cycle after `cnt` first becomes nonzero. It falls one cycle after the last counter and pend flag clear.

## Structure
- Shared package `pp_pkg` holds:
  - `PP_DB_CYCLES_DEFAULT` = 4.
  - The `PP_1` state encodings `SA`..`SD`, so benches for both stages share one definition.
- Sub-module `pp_debounce` is one channel: synchroniser, counter, `db`, and rising-edge request. It has ports `Clk`, `Rst`, `raw`, `req`, `active`, and is instantiated twice.
- Top level `pp_input_cond` contains the two instances, the arbiter and pend flags, and the output registers.

## Test plan
- **Reset:** hold `Rst`=0 with `btn_x`=`btn_y`=1 → `x`=`y`=`busy`=0 throughout. Release → `x` pulse at E6, `y` pulse at E7, each exactly 1 cycle.
- **Clean press (`DB_CYCLES`=4):** raise `btn_x` before E0 and hold for 20 cycles → a single `x` pulse after E6, `y` stays 0, no pulse on release.
- **Glitch rejection:** `btn_x` high for 3 sampled cycles, then low → `x` never asserts and `busy` returns to 0. Repeat with 4 cycles → `x` pulses.
- **Simultaneous press:** `btn_x` and `btn_y` rise in the same cycle → `x` at E6, `y` at E7, never both high.
- **Reset mid-debounce:** assert `Rst`=0 at E3 of an X press for 2 cycles → `x`/`cnt`/`busy` clear at once. Once `Rst` releases with `btn_x` still held → exactly one `x` pulse, 6 edges after the first post-reset edge that samples `btn_x`.
- **Chain to `PP_1`:** connect `x`/`y` to `PP_1`, press X then Y, at least 10 cycles apart → `PP_1` moves SA→SB→SC and `q` matches its stand-alone bench.
